// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned DEF_PC_W        = 32;
    localparam int unsigned DEF_IMEM_ADDR_W = 5;
    localparam int unsigned DEF_IMEM_W      = 32;
    localparam int unsigned DEF_IMEM_DEPTH  = 10;
    localparam int unsigned DEF_CNT_W       = 16;

    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;
    localparam int unsigned PC_STEP     = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_counter.sv
// Saturating up-counter with enable, used to count decoder handshakes.
module fetch_counter
    import fetch_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_count <= '0;
        end else if (i_en && (o_count != '1)) begin
            o_count <= o_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses the combinational instruction memory and
// presents fetched instructions to the decoder through a valid/ready register.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     PC_W        = DEF_PC_W,
    parameter int unsigned     IMEM_ADDR_W = DEF_IMEM_ADDR_W,
    parameter int unsigned     IMEM_W      = DEF_IMEM_W,
    parameter int unsigned     IMEM_DEPTH  = DEF_IMEM_DEPTH,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int unsigned     CNT_W       = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [IMEM_ADDR_W-1:0] Readaddress,
    input  logic [IMEM_W-1:0]      Instruction,
    input  logic                   BranchTaken,
    input  logic [PC_W-1:0]        BranchTarget,
    input  logic                   IfReady,
    output logic                   IfValid,
    output logic [IMEM_W-1:0]      IfInstr,
    output logic [PC_W-1:0]        IfPc,
    output logic                   Halted,
    output logic                   FetchFault,
    output logic [CNT_W-1:0]       FetchCount
);

    localparam int unsigned WORD_W = PC_W - 2;

    fetch_state_t      r_state;
    logic [PC_W-1:0]   r_pc;
    logic [WORD_W-1:0] w_word;
    logic              w_end;
    logic              w_load;
    logic              w_hs;
    logic              w_misaligned;
    logic              w_ebreak;

    // Memory address depends on the PC register only, never on inputs.
    assign Readaddress  = r_pc[IMEM_ADDR_W+1:2];
    assign w_word       = r_pc[PC_W-1:2];
    assign w_end        = (w_word >= WORD_W'(IMEM_DEPTH)) ||
                          (w_word >= WORD_W'(2 ** IMEM_ADDR_W));
    assign w_load       = !IfValid || IfReady;
    assign w_hs         = IfValid && IfReady;
    assign w_misaligned = (BranchTarget[1:0] != 2'b00);
    assign w_ebreak     = (Instruction == IMEM_W'(EBREAK_INSN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            IfValid    <= 1'b0;
            IfInstr    <= '0;
            IfPc       <= '0;
            Halted     <= 1'b0;
            FetchFault <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_RUN;
                S_RUN: begin
                    // Redirect wins over end-of-program, load and stall.
                    if (BranchTaken) begin
                        IfValid <= 1'b0;
                        if (w_misaligned) begin
                            FetchFault <= 1'b1;
                            r_state    <= S_FAULT;
                        end else begin
                            r_pc <= BranchTarget;
                        end
                    end else if (w_end) begin
                        Halted  <= 1'b1;
                        r_state <= S_HALT;
                        if (w_hs) IfValid <= 1'b0;
                    end else if (w_load) begin
                        IfInstr <= Instruction;
                        IfPc    <= r_pc;
                        IfValid <= 1'b1;
                        r_pc    <= r_pc + PC_W'(PC_STEP);
                        if (w_ebreak) begin
                            Halted  <= 1'b1;
                            r_state <= S_HALT;
                        end
                    end
                end
                default: begin
                    // Terminal states only drain the output register.
                    if (w_hs) IfValid <= 1'b0;
                end
            endcase
        end
    end

    fetch_counter #(
        .CNT_W(CNT_W)
    ) u_fetch_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_hs),
        .o_count(FetchCount)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a behavioural instruction stream model.
module tb_instr_fetch_unit;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk;
    logic        rst_n;
    logic [4:0]  Readaddress;
    logic [31:0] Instruction;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        IfReady;
    logic        IfValid;
    logic [31:0] IfInstr;
    logic [31:0] IfPc;
    logic        Halted;
    logic        FetchFault;
    logic [15:0] FetchCount;

    logic [31:0] mem [0:31];
    int n_cmp = 0;
    int n_bad = 0;

    assign Instruction = mem[Readaddress];

    instr_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Readaddress (Readaddress),
        .Instruction (Instruction),
        .BranchTaken (BranchTaken),
        .BranchTarget(BranchTarget),
        .IfReady     (IfReady),
        .IfValid     (IfValid),
        .IfInstr     (IfInstr),
        .IfPc        (IfPc),
        .Halted      (Halted),
        .FetchFault  (FetchFault),
        .FetchCount  (FetchCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 32; i++) begin
            do mem[i] = $urandom; while (mem[i] == EBREAK);
        end
        mem[0] = 32'h00F0_0193;
        mem[1] = 32'h0030_0113;
        mem[2] = 32'h4021_8233;
        mem[3] = 32'h4032_02B3;
    endtask

    // Leaves rst_n released just after a rising edge; the next edge leaves idle.
    task automatic do_reset();
        rst_n        = 1'b0;
        BranchTaken  = 1'b0;
        BranchTarget = '0;
        IfReady      = 1'b0;
        #2;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        IfReady = 1'b1;
        repeat (4) step();
        #2 rst_n = 1'b0;
        #1;
        n_cmp += 7;
        if (IfValid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b expected 0", IfValid); end
        if (IfInstr !== '0) begin n_bad++; $display("FAIL rst_instr: got %h expected 0", IfInstr); end
        if (IfPc !== '0) begin n_bad++; $display("FAIL rst_pc: got %h expected 0", IfPc); end
        if (Halted !== 1'b0) begin n_bad++; $display("FAIL rst_halted: got %b expected 0", Halted); end
        if (FetchFault !== 1'b0) begin n_bad++; $display("FAIL rst_fault: got %b expected 0", FetchFault); end
        if (FetchCount !== '0) begin n_bad++; $display("FAIL rst_count: got %0d expected 0", FetchCount); end
        if (Readaddress !== '0) begin n_bad++; $display("FAIL rst_addr: got %0d expected 0", Readaddress); end
    endtask

    task automatic test_sequential();
        do_reset();
        IfReady = 1'b1;
        step();
        n_cmp++;
        if (IfValid !== 1'b0) begin n_bad++; $display("FAIL seq_idle_valid: got %b expected 0", IfValid); end
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp += 4;
            if (IfValid !== 1'b1) begin n_bad++; $display("FAIL seq_valid%0d: got %b expected 1", k, IfValid); end
            if (IfPc !== 32'(4 * k)) begin n_bad++; $display("FAIL seq_pc%0d: got %h expected %h", k, IfPc, 4 * k); end
            if (IfInstr !== mem[k]) begin n_bad++; $display("FAIL seq_instr%0d: got %h expected %h", k, IfInstr, mem[k]); end
            if (FetchCount !== 16'(k)) begin n_bad++; $display("FAIL seq_cnt%0d: got %0d expected %0d", k, FetchCount, k); end
        end
        step();
        n_cmp++;
        if (FetchCount !== 16'd4) begin n_bad++; $display("FAIL seq_cnt_final: got %0d expected 4", FetchCount); end
    endtask

    // Stall at IfPc=4, then redirect to 0x14, then a misaligned redirect.
    task automatic test_stall_branch_fault();
        do_reset();
        IfReady = 1'b1;
        repeat (3) step();
        IfReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp += 3;
            if (IfPc !== 32'd4) begin n_bad++; $display("FAIL stall_pc%0d: got %h expected 4", k, IfPc); end
            if (IfInstr !== 32'h0030_0113) begin n_bad++; $display("FAIL stall_instr%0d: got %h expected 00300113", k, IfInstr); end
            if (Readaddress !== 5'd2) begin n_bad++; $display("FAIL stall_addr%0d: got %0d expected 2", k, Readaddress); end
        end
        IfReady = 1'b1;
        step();
        n_cmp++;
        if (IfPc !== 32'd8) begin n_bad++; $display("FAIL stall_release: got %h expected 8", IfPc); end
        BranchTaken = 1'b1; BranchTarget = 32'h14;
        step();
        BranchTaken = 1'b0;
        n_cmp += 3;
        if (IfValid !== 1'b0) begin n_bad++; $display("FAIL br_flush: got %b expected 0", IfValid); end
        if (Readaddress !== 5'd5) begin n_bad++; $display("FAIL br_addr: got %0d expected 5", Readaddress); end
        if (FetchCount !== 16'd3) begin n_bad++; $display("FAIL br_cnt: got %0d expected 3", FetchCount); end
        step();
        n_cmp += 3;
        if (IfValid !== 1'b1) begin n_bad++; $display("FAIL br_valid: got %b expected 1", IfValid); end
        if (IfPc !== 32'h14) begin n_bad++; $display("FAIL br_pc: got %h expected 14", IfPc); end
        if (IfInstr !== mem[5]) begin n_bad++; $display("FAIL br_instr: got %h expected %h", IfInstr, mem[5]); end
        BranchTaken = 1'b1; BranchTarget = 32'h16;
        step();
        BranchTaken = 1'b1; BranchTarget = 32'h0;
        n_cmp += 2;
        if (FetchFault !== 1'b1) begin n_bad++; $display("FAIL flt_flag: got %b expected 1", FetchFault); end
        if (IfValid !== 1'b0) begin n_bad++; $display("FAIL flt_valid: got %b expected 0", IfValid); end
        step();
        BranchTaken = 1'b0;
        repeat (2) step();
        n_cmp += 4;
        if (IfValid !== 1'b0) begin n_bad++; $display("FAIL flt_noload: got %b expected 0", IfValid); end
        if (Readaddress !== 5'd6) begin n_bad++; $display("FAIL flt_addr: got %0d expected 6", Readaddress); end
        if (FetchFault !== 1'b1) begin n_bad++; $display("FAIL flt_sticky: got %b expected 1", FetchFault); end
        if (Halted !== 1'b0) begin n_bad++; $display("FAIL flt_halted: got %b expected 0", Halted); end
    endtask

    task automatic test_end_of_program();
        do_reset();
        IfReady = 1'b1;
        repeat (11) step();
        n_cmp += 3;
        if (IfPc !== 32'h24) begin n_bad++; $display("FAIL end_lastpc: got %h expected 24", IfPc); end
        if (IfInstr !== mem[9]) begin n_bad++; $display("FAIL end_lastinstr: got %h expected %h", IfInstr, mem[9]); end
        if (Halted !== 1'b0) begin n_bad++; $display("FAIL end_early_halt: got %b expected 0", Halted); end
        step();
        n_cmp += 3;
        if (Halted !== 1'b1) begin n_bad++; $display("FAIL end_halted: got %b expected 1", Halted); end
        if (IfValid !== 1'b0) begin n_bad++; $display("FAIL end_drain: got %b expected 0", IfValid); end
        if (FetchCount !== 16'd10) begin n_bad++; $display("FAIL end_cnt: got %0d expected 10", FetchCount); end
    endtask

    task automatic test_ebreak();
        mem[2] = EBREAK;
        do_reset();
        IfReady = 1'b1;
        repeat (4) step();
        n_cmp += 3;
        if (IfPc !== 32'd8) begin n_bad++; $display("FAIL ebk_pc: got %h expected 8", IfPc); end
        if (IfInstr !== EBREAK) begin n_bad++; $display("FAIL ebk_instr: got %h expected %h", IfInstr, EBREAK); end
        if (Halted !== 1'b1) begin n_bad++; $display("FAIL ebk_halted: got %b expected 1", Halted); end
        repeat (3) step();
        n_cmp += 3;
        if (IfValid !== 1'b0) begin n_bad++; $display("FAIL ebk_drain: got %b expected 0", IfValid); end
        if (IfPc !== 32'd8) begin n_bad++; $display("FAIL ebk_nonext: got %h expected 8", IfPc); end
        if (FetchCount !== 16'd3) begin n_bad++; $display("FAIL ebk_cnt: got %0d expected 3", FetchCount); end
        mem[2] = 32'h4021_8233;
    endtask

    // Decoder sees the program in order from each accepted redirect target.
    task automatic test_random();
        int exp_pc;
        int cnt;
        fill_mem();
        do_reset();
        IfReady = 1'b1;
        step();
        exp_pc = 0;
        cnt = 0;
        for (int cyc = 0; cyc < 3000 && !(Halted && !IfValid); cyc++) begin
            IfReady      = (cyc >= 400) ? 1'b1 : ($urandom_range(0, 3) != 0);
            BranchTaken  = (cyc < 300) && !Halted && ($urandom_range(0, 15) == 0);
            BranchTarget = 32'(4 * $urandom_range(0, 9));
            if (IfValid && IfReady) begin
                n_cmp += 2;
                if (IfPc !== 32'(exp_pc)) begin n_bad++; $display("FAIL rnd_pc: got %h expected %h", IfPc, exp_pc); end
                if (IfInstr !== mem[(exp_pc >> 2) & 31]) begin
                    n_bad++; $display("FAIL rnd_instr: got %h expected %h", IfInstr, mem[(exp_pc >> 2) & 31]);
                end
                exp_pc += 4;
                cnt++;
            end
            if (BranchTaken) exp_pc = int'(BranchTarget);
            step();
        end
        BranchTaken = 1'b0;
        n_cmp += 3;
        if (!(Halted && !IfValid)) begin n_bad++; $display("FAIL rnd_timeout: got halted=%b valid=%b expected 1/0", Halted, IfValid); end
        if (FetchCount !== 16'(cnt)) begin n_bad++; $display("FAIL rnd_cnt: got %0d expected %0d", FetchCount, cnt); end
        if (exp_pc != 40) begin n_bad++; $display("FAIL rnd_endpc: got %h expected 28", exp_pc); end
    endtask

    initial begin
        rst_n        = 1'b0;
        BranchTaken  = 1'b0;
        BranchTarget = '0;
        IfReady      = 1'b0;
        fill_mem();
        test_reset();
        test_sequential();
        test_stall_branch_fault();
        test_end_of_program();
        test_ebreak();
        for (int r = 0; r < 4; r++) test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
